// File: rtl/reaction_ctrl.sv
// Reaction-timer controller: start-light countdown, random hold-off, timing window
// and false-start detection, with pulses that gate a downstream reaction counter.
module reaction_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       trigger,
    input  logic       stop,
    output logic [9:0] ledr,
    output logic       start_counting,
    output logic       end_counting,
    output logic       false_start
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHTS,
        S_DELAY,
        S_TIMING,
        S_FAULT
    } state_t;

    state_t      r_state;
    logic        r_trig_d;
    logic        r_stop_d;
    logic [8:0]  r_step;
    logic [10:0] r_dly;
    logic [6:0]  r_lfsr;

    logic w_trig_edge;
    logic w_stop_edge;

    assign w_trig_edge = trigger & ~r_trig_d;
    assign w_stop_edge = stop & ~r_stop_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            // Held-high buttons must not look like a fresh press after reset.
            r_trig_d       <= 1'b1;
            r_stop_d       <= 1'b1;
            r_step         <= 9'd0;
            r_dly          <= 11'd0;
            r_lfsr         <= 7'h01;
            ledr           <= 10'h000;
            start_counting <= 1'b0;
            end_counting   <= 1'b0;
            false_start    <= 1'b0;
        end else begin
            r_trig_d       <= trigger;
            r_stop_d       <= stop;
            r_lfsr         <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            start_counting <= 1'b0;
            end_counting   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_trig_edge) begin
                        r_state <= S_LIGHTS;
                        ledr    <= 10'h000;
                        r_step  <= 9'd0;
                    end
                end
                S_LIGHTS: begin
                    if (w_stop_edge) begin
                        r_state     <= S_FAULT;
                        false_start <= 1'b1;
                        ledr        <= 10'h3FF;
                    end else if (tick) begin
                        if (r_step == 9'd499) begin
                            r_step <= 9'd0;
                            ledr   <= {ledr[8:0], 1'b1};
                            // This shift lights the last lamp; arm the random hold-off.
                            if (ledr[8:0] == 9'h1FF) begin
                                r_state <= S_DELAY;
                                r_dly   <= {r_lfsr, 4'b0000};
                            end
                        end else begin
                            r_step <= r_step + 9'd1;
                        end
                    end
                end
                S_DELAY: begin
                    // Stop is tested first so a press on the final tick still faults.
                    if (w_stop_edge) begin
                        r_state     <= S_FAULT;
                        false_start <= 1'b1;
                        ledr        <= 10'h3FF;
                    end else if (tick) begin
                        if (r_dly == 11'd1) begin
                            r_state        <= S_TIMING;
                            ledr           <= 10'h000;
                            start_counting <= 1'b1;
                        end
                        r_dly <= r_dly - 11'd1;
                    end
                end
                S_TIMING: begin
                    if (w_stop_edge) begin
                        r_state      <= S_IDLE;
                        end_counting <= 1'b1;
                    end
                end
                S_FAULT: begin
                    if (w_trig_edge) begin
                        r_state     <= S_IDLE;
                        false_start <= 1'b0;
                        ledr        <= 10'h000;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomized-tick bench for reaction_ctrl; expected light/delay timing is derived
// from tick counts and a precomputed LFSR sequence indexed by cycles since reset.
module tb_reaction_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       trigger = 1'b0;
    logic       stop = 1'b0;
    logic [9:0] ledr;
    logic       start_counting;
    logic       end_counting;
    logic       false_start;

    int         n_pass = 0;
    int         n_chk = 0;
    int         cyc = 0;
    logic [6:0] seq [127];

    reaction_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick          (tick),
        .trigger       (trigger),
        .stop          (stop),
        .ledr          (ledr),
        .start_counting(start_counting),
        .end_counting  (end_counting),
        .false_start   (false_start)
    );

    always #5 clk = ~clk;

    // cyc = number of non-reset edges since the last reset edge, so the LFSR
    // holds seq[cyc % 127] between edges.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic cyc1(input logic t, input logic tr, input logic sp);
        tick = t; trigger = tr; stop = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc1(0, 0, 0);
        rst_n = 1'b1;
        cyc1(0, 0, 0);
    endtask

    // Trigger then 5000 ticks; returns the hold-off length the model expects.
    task automatic do_lights(input string tag, input int tgt, output int dly);
        int n;
        int g;
        bit bad;
        logic [9:0] e;
        cyc1(0, 1, 0);
        n_chk++;
        if (ledr !== 10'h000) $display("FAIL %s_enter: ledr=%h want 000", tag, ledr);
        else n_pass++;
        cyc1(0, 0, 0);
        n = 0; bad = 0;
        while (n < 5000) begin
            if (n == 4999 && tgt != 0) begin
                g = 0;
                while (seq[cyc % 127] != 7'(tgt) && g < 200) begin cyc1(0, 0, 0); g++; end
            end else begin
                repeat ($urandom_range(0, 1)) cyc1(0, 0, 0);
            end
            cyc1(1, 0, 0);
            n++;
            if (start_counting || end_counting || false_start) bad = 1;
            if (n % 500 == 0 || n % 500 == 499) begin
                e = 10'((1 << (n / 500)) - 1);
                n_chk++;
                if (ledr !== e) $display("FAIL %s_lights n=%0d: ledr=%h want %h", tag, n, ledr, e);
                else n_pass++;
            end
        end
        dly = int'({seq[(cyc - 1) % 127], 4'b0000});
        n_chk++;
        if (bad) $display("FAIL %s_lights_pulses: pulse or false_start seen, want none", tag);
        else n_pass++;
    endtask

    // Deliver dly ticks; race=1 presses stop together with the final tick.
    task automatic do_delay(input string tag, input int dly, input bit race);
        bit bad;
        bad = 0;
        for (int k = 1; k <= dly; k++) begin
            repeat ($urandom_range(0, 1)) cyc1(0, 0, 0);
            if (k == dly && race) cyc1(1, 0, 1);
            else cyc1(1, 0, 0);
            if (k < dly && (start_counting || ledr !== 10'h3FF || false_start)) bad = 1;
        end
        n_chk++;
        if (bad) $display("FAIL %s_delay_hold: early start or ledr left 3FF", tag);
        else n_pass++;
        if (race) begin
            n_chk++;
            if ({false_start, ledr, start_counting, end_counting} !== {1'b1, 10'h3FF, 2'b00})
                $display("FAIL %s_race: fs=%b ledr=%h sc=%b ec=%b want 1 3ff 0 0",
                         tag, false_start, ledr, start_counting, end_counting);
            else n_pass++;
        end else begin
            n_chk++;
            if ({start_counting, ledr, false_start} !== {1'b1, 10'h000, 1'b0})
                $display("FAIL %s_start: sc=%b ledr=%h fs=%b want 1 000 0",
                         tag, start_counting, ledr, false_start);
            else n_pass++;
        end
        cyc1(0, 0, 0);
        n_chk++;
        if (start_counting !== 1'b0) $display("FAIL %s_start_width: sc=%b want 0", tag, start_counting);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc1(0, 0, 0);
        cyc1(0, 0, 0);
        n_chk++;
        if ({ledr, start_counting, end_counting, false_start} !== 13'h0)
            $display("FAIL reset_outputs: ledr=%h sc=%b ec=%b fs=%b want all 0",
                     ledr, start_counting, end_counting, false_start);
        else n_pass++;
        n_chk++;
        if (dut.r_lfsr !== 7'h01) $display("FAIL reset_lfsr: got %h want 01", dut.r_lfsr);
        else n_pass++;
        rst_n = 1'b1;
        cyc1(0, 0, 0);
    endtask

    task automatic test_nominal();
        int dly;
        bit bad;
        do_lights("nom", 0, dly);
        do_delay("nom", dly, 0);
        bad = 0;
        repeat ($urandom_range(5, 40)) begin
            cyc1(1, 0, 0);
            if (end_counting || start_counting) bad = 1;
        end
        cyc1(0, 1, 0);
        cyc1(0, 0, 0);
        n_chk++;
        if (bad || ledr !== 10'h000) $display("FAIL nom_timing_quiet: bad=%0d ledr=%h want 0 000", bad, ledr);
        else n_pass++;
        cyc1(0, 0, 1);
        n_chk++;
        if ({end_counting, start_counting} !== 2'b10)
            $display("FAIL nom_end: ec=%b sc=%b want 1 0", end_counting, start_counting);
        else n_pass++;
        cyc1(0, 0, 1);
        n_chk++;
        if (end_counting !== 1'b0) $display("FAIL nom_end_width: ec=%b want 0", end_counting);
        else n_pass++;
        cyc1(0, 0, 0);
        cyc1(0, 0, 1);
        cyc1(0, 0, 0);
        n_chk++;
        if ({end_counting, false_start, ledr} !== 12'h0)
            $display("FAIL nom_idle_stop: ec=%b fs=%b ledr=%h want 0 0 000", end_counting, false_start, ledr);
        else n_pass++;
    endtask

    task automatic test_lfsr();
        int dly;
        int cnt;
        bit bad;
        bit seen [128];
        do_reset();
        do_lights("l05", 5, dly);
        n_chk++;
        if (dly != 80) $display("FAIL lfsr05_dly: got %0d want 80", dly);
        else n_pass++;
        do_delay("l05", 80, 0);
        cyc1(0, 0, 1);
        cyc1(0, 0, 0);
        bad = 0; cnt = 0;
        for (int i = 0; i < 128; i++) seen[i] = 0;
        for (int i = 0; i < 127; i++) begin
            cyc1(0, 0, 0);
            if (dut.r_lfsr !== seq[cyc % 127]) bad = 1;
            if (!seen[dut.r_lfsr] && dut.r_lfsr != 7'h0) cnt++;
            seen[dut.r_lfsr] = 1;
        end
        n_chk++;
        if (bad) $display("FAIL lfsr_seq: register departs from x^7+x^6+1 sequence");
        else n_pass++;
        n_chk++;
        if (cnt != 127) $display("FAIL lfsr_cover: distinct nonzero=%0d want 127", cnt);
        else n_pass++;
    endtask

    task automatic test_false_start();
        do_reset();
        cyc1(0, 1, 0);
        cyc1(0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            repeat ($urandom_range(0, 1)) cyc1(0, 0, 0);
            cyc1(1, 0, 0);
        end
        n_chk++;
        if (ledr !== 10'h007) $display("FAIL fs_three: ledr=%h want 007", ledr);
        else n_pass++;
        cyc1(0, 0, 1);
        n_chk++;
        if ({false_start, ledr, start_counting, end_counting} !== {1'b1, 10'h3FF, 2'b00})
            $display("FAIL fs_fault: fs=%b ledr=%h sc=%b ec=%b want 1 3ff 0 0",
                     false_start, ledr, start_counting, end_counting);
        else n_pass++;
        cyc1(0, 0, 0);
        cyc1(0, 0, 1);
        cyc1(1, 0, 0);
        n_chk++;
        if ({false_start, ledr, end_counting} !== {1'b1, 10'h3FF, 1'b0})
            $display("FAIL fs_stop_ignored: fs=%b ledr=%h ec=%b want 1 3ff 0", false_start, ledr, end_counting);
        else n_pass++;
        cyc1(0, 1, 0);
        n_chk++;
        if ({ledr, start_counting, end_counting, false_start} !== 13'h0)
            $display("FAIL fs_clear: ledr=%h sc=%b ec=%b fs=%b want all 0",
                     ledr, start_counting, end_counting, false_start);
        else n_pass++;
        cyc1(0, 0, 0);
    endtask

    task automatic test_race();
        int dly;
        do_reset();
        do_lights("race", 0, dly);
        do_delay("race", dly, 1);
        cyc1(0, 1, 0);
        cyc1(0, 0, 0);
        n_chk++;
        if ({false_start, ledr} !== 11'h0) $display("FAIL race_clear: fs=%b ledr=%h want 0 000", false_start, ledr);
        else n_pass++;
    endtask

    task automatic test_held();
        rst_n = 1'b0;
        cyc1(0, 1, 0);
        cyc1(0, 1, 0);
        rst_n = 1'b1;
        repeat (600) cyc1(1, 1, 0);
        n_chk++;
        if (ledr !== 10'h000) $display("FAIL held_idle: ledr=%h want 000", ledr);
        else n_pass++;
        cyc1(0, 0, 0);
        cyc1(0, 1, 0);
        cyc1(0, 0, 0);
        repeat (500) cyc1(1, 0, 0);
        n_chk++;
        if (ledr !== 10'h001) $display("FAIL held_repress: ledr=%h want 001", ledr);
        else n_pass++;
    endtask

    task automatic test_midrun_reset();
        int dly;
        do_reset();
        do_lights("mid", 0, dly);
        do_delay("mid", dly, 0);
        rst_n = 1'b0;
        cyc1(1, 0, 1);
        n_chk++;
        if ({ledr, start_counting, end_counting, false_start} !== 13'h0 || dut.r_lfsr !== 7'h01)
            $display("FAIL mid_reset: ledr=%h sc=%b ec=%b fs=%b lfsr=%h want 0 0 0 0 01",
                     ledr, start_counting, end_counting, false_start, dut.r_lfsr);
        else n_pass++;
        rst_n = 1'b1;
        cyc1(0, 0, 0);
        n_chk++;
        if ({start_counting, end_counting} !== 2'b00)
            $display("FAIL mid_after: sc=%b ec=%b want 0 0", start_counting, end_counting);
        else n_pass++;
        cyc1(0, 0, 1);
        cyc1(0, 0, 0);
        n_chk++;
        if ({start_counting, end_counting, ledr} !== 12'h0)
            $display("FAIL mid_no_end: sc=%b ec=%b ledr=%h want 0 0 000", start_counting, end_counting, ledr);
        else n_pass++;
    endtask

    initial begin
        seq[0] = 7'h01;
        for (int i = 1; i < 127; i++) seq[i] = {seq[i-1][5:0], seq[i-1][6] ^ seq[i-1][5]};
        test_reset();
        test_nominal();
        test_lfsr();
        test_false_start();
        test_race();
        test_held();
        test_midrun_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
